// File: rtl/ram_io_responder.sv
// ram_io_responder
// Target side of the CPU byte bus: 128 KB of byte RAM plus an I/O window
// at mem_a[17:16] == 2'b11.
//   0x30000       read pops the rx FIFO (0x00 when empty),
//                 write pushes a nonzero byte into the tx FIFO
//   0x30004..7    read returns a byte of the 32-bit cycle counter;
//                 byte 0 takes a snapshot so bytes 1..3 are coherent.
//                 A write pushes 0x00 into tx and sets the sticky halt flag.
// Every non-write cycle is treated as a read, and the result is registered
// into mem_din at that edge.
//
// Ports
//   clk_in, rst_in         clock, asynchronous active-high reset
//   mem_a, mem_wr,
//   mem_dout, mem_din      CPU byte bus
//   rx_valid/rx_data/
//   rx_ready               incoming byte stream into the rx FIFO
//   tx_valid/tx_data/
//   tx_ready               outgoing byte stream from the tx FIFO
//   cpu_rdy                tx FIFO has room (drives the CPU's rdy_in)
//   halt, tx_overflow      sticky status flags
module ram_io_responder #(
    parameter int RAM_AW  = 17,
    parameter int FIFO_AW = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        cpu_rdy,
    output logic        halt,
    output logic        tx_overflow
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0] ram [0:(2**RAM_AW)-1];

    logic [7:0]       rx_mem [0:DEPTH-1];
    logic [7:0]       tx_mem [0:DEPTH-1];
    logic [FIFO_AW:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic             rx_empty, rx_full, tx_empty, tx_full;
    logic             rx_push, rx_pop, tx_req, tx_push, tx_pop;
    logic [7:0]       tx_wdata;

    logic [31:0] cycle_cnt;
    logic [31:0] cnt_snap;

    logic [1:0] region;
    logic       is_ram, is_io_data, is_io_cnt;
    logic       unused_addr;

    assign unused_addr = ^mem_a[31:18];

    assign region     = mem_a[17:16];
    assign is_ram     = ~region[1];
    assign is_io_data = (region == 2'b11) & ~mem_a[2];
    assign is_io_cnt  = (region == 2'b11) &  mem_a[2];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                      (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                      (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);

    assign rx_ready = ~rx_full;
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem[tx_rp[FIFO_AW-1:0]];
    assign cpu_rdy  = ~tx_full;

    assign rx_push = rx_valid & ~rx_full;
    assign rx_pop  = ~mem_wr & is_io_data & ~rx_empty;

    // The zero filter only applies to the data port; the halt port always
    // queues a 0x00 marker.
    assign tx_req   = mem_wr & (is_io_cnt | (is_io_data & (mem_dout != 8'h00)));
    assign tx_wdata = is_io_cnt ? 8'h00 : mem_dout;
    // Full is judged before this cycle's pop, so a push into a full FIFO is
    // dropped even when a pop happens at the same edge.
    assign tx_push  = tx_req & ~tx_full;
    assign tx_pop   = tx_valid & tx_ready;

    // Storage arrays carry no reset.
    always_ff @(posedge clk_in) begin
        if (mem_wr && is_ram)
            ram[mem_a[RAM_AW-1:0]] <= mem_dout;
        if (rx_push)
            rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_data;
        if (tx_push)
            tx_mem[tx_wp[FIFO_AW-1:0]] <= tx_wdata;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din     <= 8'h00;
            halt        <= 1'b0;
            tx_overflow <= 1'b0;
            rx_wp       <= '0;
            rx_rp       <= '0;
            tx_wp       <= '0;
            tx_rp       <= '0;
            cycle_cnt   <= 32'h0;
            cnt_snap    <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;

            if (rx_push) rx_wp <= rx_wp + (FIFO_AW+1)'(1);
            if (rx_pop)  rx_rp <= rx_rp + (FIFO_AW+1)'(1);
            if (tx_push) tx_wp <= tx_wp + (FIFO_AW+1)'(1);
            if (tx_pop)  tx_rp <= tx_rp + (FIFO_AW+1)'(1);

            if (tx_req && tx_full)
                tx_overflow <= 1'b1;
            if (mem_wr && is_io_cnt)
                halt <= 1'b1;

            if (!mem_wr) begin
                case (region)
                    2'b00, 2'b01: mem_din <= ram[mem_a[RAM_AW-1:0]];
                    2'b10:        mem_din <= 8'h00;
                    default: begin
                        if (!mem_a[2]) begin
                            mem_din <= rx_empty ? 8'h00 : rx_mem[rx_rp[FIFO_AW-1:0]];
                        end else if (mem_a[1:0] == 2'b00) begin
                            // Byte 0 freezes the counter for the following bytes.
                            cnt_snap <= cycle_cnt;
                            mem_din  <= cycle_cnt[7:0];
                        end else begin
                            mem_din <= cnt_snap[{mem_a[1:0], 3'b000} +: 8];
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// Testbench for ram_io_responder: queue/array reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_ram_io_responder;

    localparam logic [31:0] IDLE = 32'h0002_0000;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] mem_a = IDLE;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = 8'h00;
    logic [7:0]  mem_din;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        cpu_rdy;
    logic        halt;
    logic        tx_overflow;

    int n_checks = 0;
    int n_errors = 0;

    ram_io_responder dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .mem_a       (mem_a),
        .mem_wr      (mem_wr),
        .mem_dout    (mem_dout),
        .mem_din     (mem_din),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .cpu_rdy     (cpu_rdy),
        .halt        (halt),
        .tx_overflow (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: bus behaviour expressed with queues and an array.
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [7:0]  m_ram [int unsigned];
    logic [7:0]  m_din;
    logic        m_halt, m_ovf;
    logic [31:0] m_cnt, m_snap;

    task automatic model_step();
        int  txn = txq.size();
        int  rxn = rxq.size();
        bit  do_tx_pop = (txn > 0) && tx_ready;
        logic [1:0] reg_sel = mem_a[17:16];
        logic [1:0] b = mem_a[1:0];
        if (do_tx_pop) void'(txq.pop_front());
        if (mem_wr) begin
            if (reg_sel < 2) begin
                m_ram[int'(mem_a[16:0])] = mem_dout;
            end else if (reg_sel == 3) begin
                if (mem_a[2] || mem_dout != 8'h00) begin
                    if (txn < 16) txq.push_back(mem_a[2] ? 8'h00 : mem_dout);
                    else          m_ovf = 1'b1;
                end
                if (mem_a[2]) m_halt = 1'b1;
            end
        end else begin
            if (reg_sel < 2)       m_din = m_ram[int'(mem_a[16:0])];
            else if (reg_sel == 2) m_din = 8'h00;
            else if (!mem_a[2])    m_din = (rxn > 0) ? rxq.pop_front() : 8'h00;
            else if (b == 0) begin
                m_snap = m_cnt;
                m_din  = m_cnt[7:0];
            end else begin
                m_din = 8'((m_snap >> (8 * int'(b))) & 32'hFF);
            end
        end
        if (rx_valid && rxn < 16) rxq.push_back(rx_data);
        m_cnt = m_cnt + 32'd1;
    endtask

    always @(posedge clk_in) begin
        if (rst_in) begin
            rxq.delete();
            txq.delete();
            m_din  = 8'h00;
            m_halt = 1'b0;
            m_ovf  = 1'b0;
            m_cnt  = 32'h0;
            m_snap = 32'h0;
        end else begin
            model_step();
        end
        #2;
        chk("m_mem_din", mem_din, m_din);
        chk("m_tx_valid", tx_valid, txq.size() > 0);
        if (txq.size() > 0) chk("m_tx_data", tx_data, txq[0]);
        chk("m_rx_ready", rx_ready, rxq.size() < 16);
        chk("m_cpu_rdy", cpu_rdy, txq.size() < 16);
        chk("m_halt", halt, m_halt);
        chk("m_tx_overflow", tx_overflow, m_ovf);
    end

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk_in);
        mem_a = a; mem_wr = 1'b1; mem_dout = d;
        @(posedge clk_in); #3;
        mem_a = IDLE; mem_wr = 1'b0; mem_dout = 8'h00;
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] exp, input string nm);
        @(negedge clk_in);
        mem_a = a; mem_wr = 1'b0;
        @(posedge clk_in); #3;
        chk(nm, mem_din, exp);
        mem_a = IDLE;
    endtask

    task automatic push_rx(input logic [7:0] d);
        @(negedge clk_in);
        rx_valid = 1'b1; rx_data = d;
        @(posedge clk_in); #3;
        rx_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_in = 1'b1;
        #1 chk("rst_clears_mem_din", mem_din, 8'h00);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        chk("rst_mem_din", mem_din, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_cpu_rdy", cpu_rdy, 1'b1);
        chk("rst_halt", halt, 1'b0);
        chk("rst_tx_overflow", tx_overflow, 1'b0);

        // RAM and unmapped region
        wr(32'h0000_0010, 8'hA5);
        rd(32'h0000_0010, 8'hA5, "ram_read");
        rd(32'h0002_0010, 8'h00, "unmapped_read");
        wr(32'h0002_0010, 8'h5A);
        rd(32'h0000_0010, 8'hA5, "ram_kept");
        wr(32'h0001_FFFF, 8'h3C);
        rd(32'h0001_FFFF, 8'h3C, "ram_top");

        // rx FIFO
        push_rx(8'h41);
        push_rx(8'h42);
        rd(32'h0003_0000, 8'h41, "rx_pop0");
        rd(32'h0003_0000, 8'h42, "rx_pop1");
        rd(32'h0003_0000, 8'h00, "rx_empty_read");
        chk("rx_ready_after", rx_ready, 1'b1);

        // tx FIFO with zero filter
        wr(32'h0003_0000, 8'h31);
        wr(32'h0003_0000, 8'h00);
        wr(32'h0003_0000, 8'h32);
        chk("tx_head", tx_data, 8'h31);
        chk("tx_valid_q", tx_valid, 1'b1);
        @(negedge clk_in);
        tx_ready = 1'b1;
        @(posedge clk_in); #3;
        chk("tx_second", tx_data, 8'h32);
        @(posedge clk_in); #3;
        chk("tx_drained", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // tx full, overflow, and push into full with simultaneous pop
        for (int i = 0; i < 17; i++) begin
            wr(32'h0003_0000, 8'(8'h60 + i));
            if (i == 15) begin
                chk("full_cpu_rdy", cpu_rdy, 1'b0);
                chk("full_no_ovf", tx_overflow, 1'b0);
            end
        end
        chk("ovf_set", tx_overflow, 1'b1);
        tx_ready = 1'b1;
        wr(32'h0003_0000, 8'h7F);
        chk("full_pop_push_head", tx_data, 8'h61);
        chk("full_pop_cpu_rdy", cpu_rdy, 1'b1);
        repeat (20) @(posedge clk_in);
        #3;
        chk("drain_valid", tx_valid, 1'b0);
        chk("drain_cpu_rdy", cpu_rdy, 1'b1);
        tx_ready = 1'b0;

        // cycle counter snapshot
        reset_pulse();
        chk("rst_clears_ovf", tx_overflow, 1'b0);
        repeat (300) @(posedge clk_in);
        rd(32'h0003_0004, 8'h2C, "cnt_b0");
        rd(32'h0003_0005, 8'h01, "cnt_b1");
        rd(32'h0003_0006, 8'h00, "cnt_b2");
        rd(32'h0003_0007, 8'h00, "cnt_b3");

        // halt port
        wr(32'h0003_0004, 8'h77);
        chk("halt_set", halt, 1'b1);
        chk("halt_tx_valid", tx_valid, 1'b1);
        chk("halt_tx_zero", tx_data, 8'h00);
        rd(32'h0000_0010, 8'hA5, "ram_after_halt");
        reset_pulse();
        chk("halt_cleared", halt, 1'b0);
        chk("tx_cleared", tx_valid, 1'b0);
        rd(32'h0003_0004, 8'h01, "cnt_restart");

        #20;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
